// File: rtl/output_layer_accum.sv
// Output-layer MAC bank: 10 saturating class accumulators fed one hidden
// activation per beat, scores held for the downstream argmax stage.
module output_layer_accum #(
  parameter int N_INPUTS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [159:0] bias_packed,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   act_in,
  input  logic [79:0]  w_packed,
  output logic [199:0] scores_packed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         sat_flag
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam int CW = $clog2(N_INPUTS);
  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic signed [19:0] acc  [10];
  logic signed [15:0] prod [10];
  logic [20:0]        sum  [10];
  logic [19:0]        nxt  [10];
  logic               any_clamp;

  // Sum is one bit wider than acc so overflow shows as bit20 != bit19.
  always_comb begin
    any_clamp = 1'b0;
    for (int j = 0; j < 10; j++) begin
      prod[j] = $signed(act_in) * $signed(w_packed[j*8 +: 8]);
      sum[j]  = {acc[j][19], acc[j]} + {{5{prod[j][15]}}, prod[j]};
      nxt[j]  = sum[j][19:0];
      if (sum[j][20] != sum[j][19]) begin
        any_clamp = 1'b1;
        nxt[j]    = sum[j][20] ? 20'h80000 : 20'h7ffff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sat_flag <= 1'b0;
      for (int j = 0; j < 10; j++) acc[j] <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state    <= ACCUM;
          cnt      <= '0;
          sat_flag <= 1'b0;
          for (int j = 0; j < 10; j++)
            acc[j] <= {{4{bias_packed[j*16+15]}},
                       bias_packed[j*16 +: 16]};
        end
        ACCUM: if (in_valid) begin
          for (int j = 0; j < 10; j++) acc[j] <= nxt[j];
          if (any_clamp) sat_flag <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    scores_packed = '0;
    for (int j = 0; j < 10; j++)
      scores_packed[j*20 +: 20] = acc[j];
  end

endmodule

// File: tb/tb_output_layer_accum.sv
// Bench for output_layer_accum: table vectors, directed corner sequences and
// random frames against an integer reference model.
module tb_output_layer_accum;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, out_ready;
  logic [159:0] bias_packed;
  logic [7:0]   act_in;
  logic [79:0]  w_packed;

  logic         r4, v4, b4, s4, r32, v32, b32, s32;
  logic [199:0] sc4, sc32;
  logic         sel4;

  wire          cur_ready = sel4 ? r4 : r32;
  wire          cur_valid = sel4 ? v4 : v32;
  wire          cur_busy  = sel4 ? b4 : b32;
  wire          cur_sat   = sel4 ? s4 : s32;
  wire [199:0]  cur_sc    = sel4 ? sc4 : sc32;

  output_layer_accum #(.N_INPUTS(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .bias_packed(bias_packed),
    .in_valid(in_valid), .in_ready(r4), .act_in(act_in),
    .w_packed(w_packed), .scores_packed(sc4), .out_valid(v4),
    .out_ready(out_ready), .busy(b4), .sat_flag(s4));

  output_layer_accum #(.N_INPUTS(32)) u32 (
    .clk(clk), .rst(rst), .start(start), .bias_packed(bias_packed),
    .in_valid(in_valid), .in_ready(r32), .act_in(act_in),
    .w_packed(w_packed), .scores_packed(sc32), .out_valid(v32),
    .out_ready(out_ready), .busy(b32), .sat_flag(s32));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int bias_v [10];
  int act_v  [64];
  int w_v    [64][10];
  int exp_sc [10];
  bit exp_sat;
  int prev_sc [10];
  bit have_prev;

  typedef struct {
    int bias;
    int act;
    int w;
    int exp_score;
    bit exp_sat;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic int sc(input int j);
    logic signed [19:0] v;
    v = cur_sc[j*20 +: 20];
    return int'(v);
  endfunction

  function automatic int rnd_s(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  // Reference: plain integer MAC with clamping after every beat.
  task automatic model(input int n);
    longint a;
    exp_sat = 1'b0;
    for (int j = 0; j < 10; j++) begin
      a = bias_v[j];
      for (int b = 0; b < n; b++) begin
        a = a + act_v[b] * w_v[b][j];
        if (a > 524287) begin a = 524287; exp_sat = 1'b1; end
        if (a < -524288) begin a = -524288; exp_sat = 1'b1; end
      end
      exp_sc[j] = int'(a);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 10; j++) prev_sc[j] = 0;
    have_prev = 1'b1;
  endtask

  task automatic run_frame(input int n, input int gap_pct, input int hold);
    int cyc, ab;
    bit acc;
    logic [199:0] snap;
    model(n);
    if (have_prev)
      for (int j = 0; j < 10; j++) chk("hold_idle", sc(j), prev_sc[j]);
    for (int j = 0; j < 10; j++) bias_packed[j*16 +: 16] = 16'(bias_v[j]);
    out_ready = (hold == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", cur_busy, 1);
    ab = 0;
    while (ab < n && cyc < 4000) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        act_in = 8'(act_v[ab]);
        for (int j = 0; j < 10; j++) w_packed[j*8 +: 8] = 8'(w_v[ab][j]);
      end
      start = ($urandom_range(9) == 0);
      acc = in_valid && cur_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) ab++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("beats_accepted", ab, n);
    chk("done_valid", cur_valid, 1);
    chk("done_in_ready", cur_ready, 0);
    if (gap_pct == 0) chk("latency", cyc, n + 1);
    snap = cur_sc;
    for (int h = 0; h < hold; h++) begin
      start = ($urandom_range(1) == 1);
      @(posedge clk); #1;
      chk("hold_valid", cur_valid, 1);
      chk("hold_stable", (cur_sc == snap), 1);
    end
    start = 1'b0;
    for (int j = 0; j < 10; j++) chk("score", sc(j), exp_sc[j]);
    chk("sat_flag", cur_sat, exp_sat);
    if (hold > 0) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    chk("idle_valid", cur_valid, 0);
    chk("idle_busy", cur_busy, 0);
    for (int j = 0; j < 10; j++) prev_sc[j] = exp_sc[j];
    have_prev = 1'b1;
  endtask

  task automatic rand_frame();
    for (int j = 0; j < 10; j++) bias_v[j] = rnd_s(-32768, 32767);
    for (int b = 0; b < 32; b++) begin
      act_v[b] = rnd_s(-128, 127);
      for (int j = 0; j < 10; j++) w_v[b][j] = rnd_s(-128, 127);
    end
  endtask

  initial begin
    tbl[0] = '{bias: 0,      act: -128, w: -128, exp_score: 524287,  exp_sat: 1'b1};
    tbl[1] = '{bias: 0,      act: 0,    w: 0,    exp_score: 0,       exp_sat: 1'b0};
    tbl[2] = '{bias: 100,    act: 1,    w: 1,    exp_score: 132,     exp_sat: 1'b0};
    tbl[3] = '{bias: 0,      act: 127,  w: -128, exp_score: -520192, exp_sat: 1'b0};
    tbl[4] = '{bias: -10000, act: 127,  w: -128, exp_score: -524288, exp_sat: 1'b1};
    tbl[5] = '{bias: 32767,  act: 127,  w: 127,  exp_score: 524287,  exp_sat: 1'b1};

    bias_packed = '0; act_in = '0; w_packed = '0; sel4 = 1'b0;
    do_reset();
    chk("rst_scores", cur_sc, 0);
    chk("rst_ready", cur_ready, 0);
    chk("rst_valid", cur_valid, 0);
    chk("rst_busy", cur_busy, 0);
    chk("rst_sat", cur_sat, 0);

    // Basic 4-input frame on the small instance.
    sel4 = 1'b1;
    for (int j = 0; j < 10; j++) bias_v[j] = 0;
    for (int b = 0; b < 4; b++) begin
      act_v[b] = b + 1;
      for (int j = 0; j < 10; j++) w_v[b][j] = j;
    end
    run_frame(4, 0, 2);
    begin
      int best;
      best = 0;
      for (int j = 0; j < 10; j++) begin
        chk("basic_score", sc(j), 10 * j);
        if (sc(j) > sc(best)) best = j;
      end
      chk("basic_argmax", best, 9);
    end

    // Negative bias and sign handling.
    sel4 = 1'b0;
    do_reset();
    for (int j = 0; j < 10; j++) bias_v[j] = (j == 3) ? -100 : 0;
    for (int b = 0; b < 32; b++) begin
      act_v[b] = -1;
      for (int j = 0; j < 10; j++) w_v[b][j] = (j == 3) ? -128 : 0;
    end
    run_frame(32, 0, 1);
    chk("sign_score3", sc(3), 3996);
    chk("sign_score0", sc(0), 0);
    chk("sign_sat", cur_sat, 0);

    // Table of uniform frames, including saturation then clear.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 10; j++) bias_v[j] = tbl[i].bias;
      for (int b = 0; b < 32; b++) begin
        act_v[b] = tbl[i].act;
        for (int j = 0; j < 10; j++) w_v[b][j] = tbl[i].w;
      end
      run_frame(32, 0, i % 3);
      for (int j = 0; j < 10; j++) chk("tbl_score", sc(j), tbl[i].exp_score);
      chk("tbl_sat", cur_sat, tbl[i].exp_sat);
    end

    // Random frames with gaps and held backpressure.
    for (int k = 0; k < 4; k++) begin
      rand_frame();
      run_frame(32, 30, 7);
    end

    // Reset mid-frame, with every other input asserted.
    rand_frame();
    for (int j = 0; j < 10; j++) bias_packed[j*16 +: 16] = 16'(bias_v[j]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      in_valid = 1'b1;
      act_in = 8'(act_v[b]);
      for (int j = 0; j < 10; j++) w_packed[j*8 +: 8] = 8'(w_v[b][j]);
      @(posedge clk); #1;
    end
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("midrst_scores", cur_sc, 0);
    chk("midrst_ready", cur_ready, 0);
    chk("midrst_valid", cur_valid, 0);
    chk("midrst_busy", cur_busy, 0);
    chk("midrst_sat", cur_sat, 0);
    @(posedge clk); #1;
    chk("midrst_no_beat", cur_busy, 0);
    in_valid = 1'b0;
    for (int j = 0; j < 10; j++) prev_sc[j] = 0;
    have_prev = 1'b1;
    run_frame(32, 20, 3);

    // Back-to-back frames with out_ready held high.
    rand_frame();
    run_frame(32, 0, 0);
    rand_frame();
    run_frame(32, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
